// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operation codes, next-PC select codes and write-register select codes.
package cu_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ST_W    = 3;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;

  // Opcodes
  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b010011;
  localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b100110;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b100111;
  localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OP_W-1:0] OP_J     = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  // FSM states
  typedef enum logic [ST_W-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  // ALU operations
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b110;

  // Next-PC select
  localparam logic [SEL_W-1:0] PCSRC_SEQ = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_BR  = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JR  = 2'b10;
  localparam logic [SEL_W-1:0] PCSRC_J   = 2'b11;

  // Write-register select
  localparam logic [SEL_W-1:0] REGDST_RA = 2'b00;
  localparam logic [SEL_W-1:0] REGDST_RT = 2'b01;
  localparam logic [SEL_W-1:0] REGDST_RD = 2'b10;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: instruction class flags plus the
// opcode-only datapath selects (ALUOp, ALUSrcA, ALUSrcB, ExtSel).
// Ports: opCode in; is_alu/is_rtype/is_branch/is_ls/is_jump/is_halt,
//        alu_op, alu_src_a, alu_src_b, ext_sel out.
module cu_decode
  import cu_pkg::*;
(
  input  logic [OP_W-1:0]    opCode,
  output logic               is_alu,
  output logic               is_rtype,
  output logic               is_branch,
  output logic               is_ls,
  output logic               is_jump,
  output logic               is_halt,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_a,
  output logic               alu_src_b,
  output logic               ext_sel
);

  always_comb begin
    is_alu    = 1'b0;
    is_rtype  = 1'b0;
    is_branch = 1'b0;
    is_ls     = 1'b0;
    is_jump   = 1'b0;
    is_halt   = 1'b0;
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ext_sel   = 1'b1;
    case (opCode)
      OP_ADD:   begin is_alu = 1'b1; is_rtype = 1'b1; end
      OP_SUB:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = ALU_SUB; end
      OP_ADDIU: begin is_alu = 1'b1; alu_src_b = 1'b1; end
      OP_AND:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = ALU_AND; end
      OP_ANDI:  begin is_alu = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b0; alu_op = ALU_AND; end
      OP_ORI:   begin is_alu = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b0; alu_op = ALU_OR; end
      OP_XORI:  begin is_alu = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b0; alu_op = ALU_XOR; end
      OP_SLL:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_src_a = 1'b1; alu_op = ALU_SLL; end
      OP_SLTI:  begin is_alu = 1'b1; alu_src_b = 1'b1; alu_op = ALU_SLT; end
      OP_SLT:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = ALU_SLT; end
      OP_SW,
      OP_LW:    begin is_ls = 1'b1; alu_src_b = 1'b1; end
      OP_BEQ,
      OP_BNE,
      OP_BLTZ:  begin is_branch = 1'b1; alu_op = ALU_SUB; end
      OP_J,
      OP_JR,
      OP_JAL:   is_jump = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_cu.sv
// Multi-cycle MIPS-subset control unit: sequences IF/ID/EXE/MEM/WB and
// drives datapath strobes and mux selects from the current state and opcode.
// Ports: clk, Reset (sync, active-low), opCode, zero, sign in;
//        PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
//        RegDst, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR, state out.
module multi_cycle_cu
  import cu_pkg::*;
(
  input  logic               clk,
  input  logic               Reset,
  input  logic [OP_W-1:0]    opCode,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ExtSel,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [SEL_W-1:0]   PCSrc,
  output logic [SEL_W-1:0]   RegDst,
  output logic               RegWre,
  output logic               WrRegDSrc,
  output logic               DBDataSrc,
  output logic               mRD,
  output logic               mWR,
  output logic [ST_W-1:0]    state
);

  state_t st;
  logic   is_alu, is_rtype, is_branch, is_ls, is_jump, is_halt;
  logic   is_undef, is_lw, is_sw, is_jal, taken;

  cu_decode u_decode (
    .opCode    (opCode),
    .is_alu    (is_alu),
    .is_rtype  (is_rtype),
    .is_branch (is_branch),
    .is_ls     (is_ls),
    .is_jump   (is_jump),
    .is_halt   (is_halt),
    .alu_op    (ALUOp),
    .alu_src_a (ALUSrcA),
    .alu_src_b (ALUSrcB),
    .ext_sel   (ExtSel)
  );

  assign is_undef = !(is_alu || is_branch || is_ls || is_jump || is_halt);
  assign is_lw    = (opCode == OP_LW);
  assign is_sw    = (opCode == OP_SW);
  assign is_jal   = (opCode == OP_JAL);
  assign taken    = ((opCode == OP_BEQ)  &&  zero) ||
                    ((opCode == OP_BNE)  && !zero) ||
                    ((opCode == OP_BLTZ) &&  sign);
  assign state    = st;

  // State register with next-state selection
  always_ff @(posedge clk) begin
    if (!Reset) begin
      st <= S_IF;
    end else begin
      case (st)
        S_IF:     st <= S_ID;
        S_ID: begin
          if (is_alu)         st <= S_EXE_AL;
          else if (is_branch) st <= S_EXE_BR;
          else if (is_ls)     st <= S_EXE_LS;
          else if (is_halt)   st <= S_ID;
          else                st <= S_IF;
        end
        S_EXE_AL: st <= S_WB_AL;
        S_EXE_LS: st <= S_MEM;
        S_MEM:    st <= is_lw ? S_WB_LD : S_IF;
        default:  st <= S_IF;
      endcase
    end
  end

  // Per-state strobes; write strobes are masked while Reset is low
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    InsMemRW  = 1'b1;
    WrRegDSrc = !is_jal;
    PCSrc     = PCSRC_SEQ;
    RegDst    = REGDST_RT;

    if (is_jal)        RegDst = REGDST_RA;
    else if (is_rtype) RegDst = REGDST_RD;

    if (opCode == OP_J || is_jal) PCSrc = PCSRC_J;
    else if (opCode == OP_JR)     PCSrc = PCSRC_JR;

    case (st)
      S_IF:     IRWre = 1'b1;
      S_ID: begin
        PCWre  = is_jump || is_undef;
        RegWre = is_jal;
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = taken ? PCSRC_BR : PCSRC_SEQ;
      end
      S_MEM: begin
        mRD   = is_lw;
        mWR   = is_sw;
        PCWre = is_sw;
      end
      S_WB_AL: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
      end
      default: ;
    endcase

    if (!Reset) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Directed self-checking bench for multi_cycle_cu: walks add, lw, sw,
// branches, jumps, halt and a mid-instruction reset, checking state and
// strobes against hand-computed values.
module tb_multi_cycle_cu;

  logic       clk = 1'b0;
  logic       Reset;
  logic [5:0] opCode;
  logic       zero, sign;
  logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc, RegDst;
  logic       RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [2:0] state;

  int vectors = 0;
  int errors  = 0;

  multi_cycle_cu dut (
    .clk       (clk),
    .Reset     (Reset),
    .opCode    (opCode),
    .zero      (zero),
    .sign      (sign),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .ExtSel    (ExtSel),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .RegDst    (RegDst),
    .RegWre    (RegWre),
    .WrRegDSrc (WrRegDSrc),
    .DBDataSrc (DBDataSrc),
    .mRD       (mRD),
    .mWR       (mWR),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset  = 1'b0;
    opCode = 6'b000000;
    zero   = 1'b0;
    sign   = 1'b0;
    step();
    step();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_irwre", 8'(IRWre), 8'd0);
    chk("rst_pcwre", 8'(PCWre), 8'd0);
    chk("insmemrw",  8'(InsMemRW), 8'd1);

    // add: 000 -> 001 -> 110 -> 111 -> 000
    Reset = 1'b1;
    #1;
    chk("add_if_irwre", 8'(IRWre), 8'd1);
    step();
    chk("add_id_state", 8'(state), 8'd1);
    chk("add_id_pcwre", 8'(PCWre), 8'd0);
    step();
    chk("add_exe_state", 8'(state), 8'd6);
    chk("add_exe_pcwre", 8'(PCWre), 8'd0);
    chk("add_exe_regwre", 8'(RegWre), 8'd0);
    step();
    chk("add_wb_state",  8'(state), 8'd7);
    chk("add_wb_pcwre",  8'(PCWre), 8'd1);
    chk("add_wb_regdst", 8'(RegDst), 8'd2);
    chk("add_wb_regwre", 8'(RegWre), 8'd1);
    chk("add_wb_aluop",  8'(ALUOp), 8'd0);
    step();
    chk("add_end_state", 8'(state), 8'd0);

    // lw: 000 -> 001 -> 010 -> 011 -> 100 -> 000
    opCode = 6'b110001;
    step();
    chk("lw_id_state", 8'(state), 8'd1);
    chk("lw_id_srcb",  8'(ALUSrcB), 8'd1);
    step();
    chk("lw_exe_state", 8'(state), 8'd2);
    step();
    chk("lw_mem_state", 8'(state), 8'd3);
    chk("lw_mem_mrd",   8'(mRD), 8'd1);
    chk("lw_mem_mwr",   8'(mWR), 8'd0);
    chk("lw_mem_pcwre", 8'(PCWre), 8'd0);
    step();
    chk("lw_wb_state",  8'(state), 8'd4);
    chk("lw_wb_dbsrc",  8'(DBDataSrc), 8'd1);
    chk("lw_wb_regwre", 8'(RegWre), 8'd1);
    chk("lw_wb_regdst", 8'(RegDst), 8'd1);
    chk("lw_wb_pcwre",  8'(PCWre), 8'd1);
    step();
    chk("lw_end_state", 8'(state), 8'd0);

    // sw: MEM writes and ends the instruction
    opCode = 6'b110000;
    step(); step(); step();
    chk("sw_mem_state",  8'(state), 8'd3);
    chk("sw_mem_mwr",    8'(mWR), 8'd1);
    chk("sw_mem_mrd",    8'(mRD), 8'd0);
    chk("sw_mem_pcwre",  8'(PCWre), 8'd1);
    chk("sw_mem_regwre", 8'(RegWre), 8'd0);
    step();
    chk("sw_end_state", 8'(state), 8'd0);

    // beq taken
    opCode = 6'b110100;
    zero   = 1'b1;
    step(); step();
    chk("beq1_state", 8'(state), 8'd5);
    chk("beq1_pcsrc", 8'(PCSrc), 8'd1);
    chk("beq1_pcwre", 8'(PCWre), 8'd1);
    chk("beq1_aluop", 8'(ALUOp), 8'd1);
    step();
    chk("beq1_end", 8'(state), 8'd0);

    // beq not taken
    zero = 1'b0;
    step(); step();
    chk("beq0_pcsrc", 8'(PCSrc), 8'd0);
    chk("beq0_pcwre", 8'(PCWre), 8'd1);
    step();

    // bne taken when zero = 0
    opCode = 6'b110101;
    step(); step();
    chk("bne_pcsrc", 8'(PCSrc), 8'd1);
    step();

    // bltz taken when sign = 1, zero ignored
    opCode = 6'b110110;
    sign   = 1'b1;
    zero   = 1'b1;
    step(); step();
    chk("bltz_pcsrc", 8'(PCSrc), 8'd1);
    step();
    sign = 1'b0;
    zero = 1'b0;

    // jal: two-cycle, links in ID
    opCode = 6'b111010;
    step();
    chk("jal_state",  8'(state), 8'd1);
    chk("jal_pcsrc",  8'(PCSrc), 8'd3);
    chk("jal_regwre", 8'(RegWre), 8'd1);
    chk("jal_regdst", 8'(RegDst), 8'd0);
    chk("jal_wrsrc",  8'(WrRegDSrc), 8'd0);
    chk("jal_pcwre",  8'(PCWre), 8'd1);
    step();
    chk("jal_end", 8'(state), 8'd0);

    // jr
    opCode = 6'b111001;
    step();
    chk("jr_pcsrc",  8'(PCSrc), 8'd2);
    chk("jr_regwre", 8'(RegWre), 8'd0);
    step();

    // undefined opcode falls back to IF with PC+4
    opCode = 6'b000011;
    step();
    chk("undef_pcwre", 8'(PCWre), 8'd1);
    chk("undef_pcsrc", 8'(PCSrc), 8'd0);
    step();
    chk("undef_end", 8'(state), 8'd0);

    // ori: zero-extend, immediate operand, OR
    opCode = 6'b010010;
    step();
    chk("ori_extsel", 8'(ExtSel), 8'd0);
    chk("ori_srcb",   8'(ALUSrcB), 8'd1);
    chk("ori_aluop",  8'(ALUOp), 8'd3);
    step(); step();
    chk("ori_wb_regdst", 8'(RegDst), 8'd1);
    step();

    // sll: shift amount on A
    opCode = 6'b011000;
    step();
    chk("sll_srca",   8'(ALUSrcA), 8'd1);
    chk("sll_aluop",  8'(ALUOp), 8'd2);
    chk("sll_extsel", 8'(ExtSel), 8'd1);
    step(); step(); step();

    // slti: signed compare with immediate
    opCode = 6'b100110;
    step();
    chk("slti_aluop", 8'(ALUOp), 8'd5);
    step(); step(); step();

    // halt: parked in ID with no strobes
    opCode = 6'b111111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_state",  8'(state), 8'd1);
      chk("halt_strobe", 8'({PCWre, IRWre, RegWre, mRD, mWR}), 8'd0);
    end
    Reset = 1'b0;
    step();
    chk("halt_rst_state", 8'(state), 8'd0);
    Reset = 1'b1;

    // sw aborted by reset in MEM
    opCode = 6'b110000;
    step(); step(); step();
    chk("swab_state", 8'(state), 8'd3);
    Reset = 1'b0;
    #1;
    chk("swab_mwr",   8'(mWR), 8'd0);
    chk("swab_pcwre", 8'(PCWre), 8'd0);
    step();
    chk("swab_after", 8'(state), 8'd0);
    Reset = 1'b1;
    step();
    chk("swab_resume", 8'(state), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
